// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/mret sequencer that drains the pipeline, writes trap CSRs and redirects fetch
module trap_ctrl #(
  parameter int XLEN        = 32,
  parameter int VECTORED_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exception_en,
  input  logic [XLEN-1:0] exception_code,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_next,
  input  logic [XLEN-1:0] inst_cur,
  input  logic            mret_en,
  input  logic [XLEN-1:0] mip_in,
  input  logic [XLEN-1:0] mie_in,
  input  logic [XLEN-1:0] mstatus_in,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  input  logic            pipe_idle,
  output logic            stall_req,
  output logic            trap_active,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            jmp_en,
  output logic [XLEN-1:0] jmp_pc,
  output logic            trap_ack
);
  typedef enum logic [2:0] {IDLE, FLUSH, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, MRET_ST, JUMP} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d, epc_q, epc_d, tval_q, tval_d, target_q, target_d;
  logic            is_int_q, is_int_d, mret_q, mret_d;
  logic [XLEN-1:0] pend, mstat_trap, mstat_mret, trap_target;
  logic            take_int;
  logic [4:0]      int_id;
  assign pend        = mip_in & mie_in;
  assign take_int    = mstatus_in[3] & (pend[11] | pend[3] | pend[7]);
  assign int_id      = pend[11] ? 5'd11 : pend[3] ? 5'd3 : 5'd7;
  assign mstat_trap  = {mstatus_in[XLEN-1:13], 2'b11, mstatus_in[10:8], mstatus_in[3], mstatus_in[6:4], 1'b0, mstatus_in[2:0]};
  assign mstat_mret  = {mstatus_in[XLEN-1:13], 2'b00, mstatus_in[10:8], 1'b1, mstatus_in[6:4], mstatus_in[7], mstatus_in[2:0]};
  // Vectored offset applies to interrupts only; modes 2'b10/2'b11 fall back to direct
  assign trap_target = {mtvec_in[XLEN-1:2], 2'b00} +
                       ((VECTORED_EN != 0 && is_int_q && mtvec_in[1:0] == 2'b01) ? {cause_q[XLEN-3:0], 2'b00} : '0);
  // State and latched trap context
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cause_q  <= '0;
      epc_q    <= '0;
      tval_q   <= '0;
      target_q <= '0;
      is_int_q <= 1'b0;
      mret_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
      target_q <= target_d;
      is_int_q <= is_int_d;
      mret_q   <= mret_d;
    end
  end
  // Request arbitration in IDLE, then a fixed write sequence ending in a single redirect
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    tval_d   = tval_q;
    target_d = target_q;
    is_int_d = is_int_q;
    mret_d   = mret_q;
    case (state_q)
      IDLE: begin
        if (exception_en) begin
          state_d  = FLUSH;
          cause_d  = exception_code;
          epc_d    = pc;
          tval_d   = inst_cur;
          is_int_d = 1'b0;
          mret_d   = 1'b0;
        end else if (mret_en) begin
          state_d  = FLUSH;
          mret_d   = 1'b1;
        end else if (take_int) begin
          state_d  = FLUSH;
          cause_d  = {1'b1, (XLEN-1)'(int_id)};
          epc_d    = pc_next;
          tval_d   = '0;
          is_int_d = 1'b1;
          mret_d   = 1'b0;
        end
      end
      FLUSH:    state_d = pipe_idle ? (mret_q ? MRET_ST : W_MEPC) : FLUSH;
      W_MEPC:   state_d = W_MCAUSE;
      W_MCAUSE: state_d = W_MTVAL;
      W_MTVAL:  state_d = W_MSTAT;
      W_MSTAT: begin
        state_d  = JUMP;
        target_d = trap_target;
      end
      MRET_ST: begin
        state_d  = JUMP;
        target_d = mepc_in;
      end
      default:  state_d = IDLE;
    endcase
  end
  // Outputs decoded purely from the registered state
  always_comb begin
    stall_req   = state_q != IDLE;
    trap_active = state_q != IDLE;
    csr_we      = state_q inside {W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, MRET_ST};
    csr_waddr   = state_q == W_MEPC   ? 12'h341 :
                  state_q == W_MCAUSE ? 12'h342 :
                  state_q == W_MTVAL  ? 12'h343 :
                  (state_q == W_MSTAT || state_q == MRET_ST) ? 12'h300 : 12'h000;
    csr_wdata   = state_q == W_MEPC   ? epc_q :
                  state_q == W_MCAUSE ? cause_q :
                  state_q == W_MTVAL  ? tval_q :
                  state_q == W_MSTAT  ? mstat_trap :
                  state_q == MRET_ST  ? mstat_mret : '0;
    jmp_en      = state_q == JUMP;
    trap_ack    = state_q == JUMP;
    jmp_pc      = state_q == JUMP ? target_q : '0;
  end
endmodule
